mips_ifetch: RTL and testbench

//  Instruction-fetch front end of the mips core; it sits directly upstream of decode.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_if_fifo.sv | 64 ++++++
 rtl/mips_ifetch.sv | 83 ++++++++
 tb/tb_mips_ifetch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, reset defaults and the fetch-buffer entry type for the mips front end.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } if_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_if_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode; flush beats push.
module mips_if_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  if_entry_t                    push_data,
  input  logic                         pop,
  input  logic                         flush,
  output if_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  if_entry_t         storage [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrOne;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign head    = storage[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full push needs.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      storage[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_ifetch.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word fetches, buffers
// in-order responses for decode and drops stale responses after a redirect.
module mips_ifetch
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [ADDR_W-1:0]   id_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0]   DepthC = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [ADDR_W-1:0] pc_q, resp_pc_q;
  logic [CntW-1:0]   outstanding_q, outstanding_d, discard_q, fifo_count;
  logic [CntW:0]     in_use;
  logic              issue, keep, fifo_full, fifo_empty;
  if_entry_t         head, push_data;

  assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req  = ~rst & ~redirect_valid & (in_use < DepthC);
  assign imem_addr = pc_q;
  assign issue     = imem_req & imem_gnt;
  assign outstanding_d = outstanding_q + CntW'(issue) - CntW'(imem_rvalid);

  // resp_pc_q tracks the address of the next kept response, since responses return in order.
  assign keep      = imem_rvalid & (discard_q == '0) & ~redirect_valid;
  assign push_data = '{pc: resp_pc_q, instr: imem_rdata};

  mips_if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep & (~fifo_full | (id_valid & id_ready))),
    .push_data (push_data),
    .pop       (id_valid & id_ready),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign id_valid = ~fifo_empty;
  assign id_instr = id_valid ? head.instr : NOP;
  assign id_pc    = id_valid ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        pc_q      <= word_align(redirect_pc);
        resp_pc_q <= word_align(redirect_pc);
        discard_q <= outstanding_d;
      end else begin
        if (issue) pc_q <= pc_q + ADDR_W'(4);
        if (keep)  resp_pc_q <= resp_pc_q + ADDR_W'(4);
        if (imem_rvalid && discard_q != '0) discard_q <= discard_q - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_mips_ifetch.sv
// Self-checking bench for mips_ifetch: in-order memory model with random latency plus a
// queue-based model of what decode must see.
module tb_mips_ifetch;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  mips_ifetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        buf_q[$];
  logic [31:0] exp_fetch, exp_dec;
  int          n_cmp, n_fail, cyc, lat_lo, lat_hi;
  bit          obs_req, obs_resp, obs_pop;
  logic [31:0] obs_addr, obs_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive inputs at negedge, check outputs, then advance the model.
  task automatic cycle(input bit r, input bit g, input bit rdy, input bit rd,
                       input logic [31:0] rpc);
    bit    resp, exp_req, exp_val;
    mreq_t m;
    ent_t  e;
    @(negedge clk);
    rst = r; imem_gnt = g; id_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
    resp = !r && mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    exp_req = !r && !rd && (mem_q.size() + buf_q.size() < DEPTH);
    exp_val = buf_q.size() > 0;
    n_cmp++;
    if (imem_req !== exp_req) begin
      n_fail++; $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
    end
    if (exp_req) begin
      n_cmp++;
      if (imem_addr !== exp_fetch) begin
        n_fail++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, exp_fetch);
      end
    end
    n_cmp++;
    if (id_valid !== exp_val) begin
      n_fail++; $display("FAIL id_valid cyc=%0d got=%b want=%b", cyc, id_valid, exp_val);
    end
    if (exp_val) begin
      n_cmp++;
      if (id_pc !== buf_q[0].pc || id_instr !== buf_q[0].instr) begin
        n_fail++;
        $display("FAIL id_entry cyc=%0d got=%h/%h want=%h/%h", cyc, id_pc, id_instr,
                 buf_q[0].pc, buf_q[0].instr);
      end
    end
    obs_req = imem_req && g; obs_addr = imem_addr; obs_resp = resp; obs_pop = 0;
    if (r) begin
      mem_q.delete(); buf_q.delete();
      exp_fetch = RST_PC; exp_dec = RST_PC;
    end else begin
      if (exp_val && rdy) begin
        obs_pop = 1; obs_pop_pc = id_pc;
        n_cmp++;
        if (id_pc !== exp_dec) begin
          n_fail++; $display("FAIL order cyc=%0d got=%h want=%h", cyc, id_pc, exp_dec);
        end
        exp_dec += 32'd4;
        void'(buf_q.pop_front());
      end
      if (resp) begin
        m = mem_q.pop_front();
        if (!m.stale && !rd) begin
          e.pc = m.addr; e.instr = mem_word(m.addr);
          buf_q.push_back(e);
        end
      end
      if (exp_req && g) begin
        m.addr = exp_fetch; m.due = cyc + 1 + int'($urandom_range(lat_hi, lat_lo)); m.stale = 0;
        mem_q.push_back(m);
        exp_fetch += 32'd4;
      end
      if (rd) begin
        buf_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_fetch = {rpc[31:2], 2'b00}; exp_dec = exp_fetch;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((mem_q.size() > 0 || buf_q.size() > 0) && k < 30) begin
      cycle(0, 0, 1, 0, 32'h0); k++;
    end
    n_cmp++;
    if (mem_q.size() > 0 || buf_q.size() > 0) begin
      n_fail++; $display("FAIL drain_timeout got=%0d/%0d want=0/0", mem_q.size(), buf_q.size());
    end
  endtask

  task automatic test_reset();
    cycle(1, 1, 1, 1, 32'h0000_0400);
    cycle(1, 0, 0, 0, 32'h0);
    @(posedge clk); #1;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got=%b%b want=00", id_valid, imem_req);
    end
    cycle(0, 0, 1, 0, 32'h0);
    n_cmp++;
    if (obs_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_addr got=%h want=%h", obs_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int pops;
    lat_lo = 0; lat_hi = 0; pops = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 1, 0, 32'h0);
      if (i >= 10 && obs_pop) pops++;
    end
    n_cmp++;
    if (pops < 13) begin
      n_fail++; $display("FAIL stream_rate got=%0d want>=13", pops);
    end
  endtask

  task automatic test_backpressure();
    int nreq, grants;
    logic [31:0] first_addr;
    bit got_first;
    drain();
    nreq = 0; got_first = 0; first_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 0, 32'h0);
      if (obs_req) begin
        nreq++;
        if (!got_first) begin first_addr = obs_addr; got_first = 1; end
      end
    end
    n_cmp++;
    if (nreq != 2) begin
      n_fail++; $display("FAIL bp_requests got=%0d want=2", nreq);
    end
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_req_low got=%b want=0", imem_req);
    end
    grants = 0; got_first = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, 0, 32'h0);
      if (obs_req) grants++;
      if (obs_pop && !got_first) begin
        got_first = 1;
        n_cmp++;
        if (obs_pop_pc !== first_addr) begin
          n_fail++; $display("FAIL bp_first_pop got=%h want=%h", obs_pop_pc, first_addr);
        end
      end
    end
    n_cmp++;
    if (grants == 0 || !got_first) begin
      n_fail++; $display("FAIL bp_resume got=%0d grants want>0", grants);
    end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] a0;
    int pops;
    drain();
    cycle(0, 0, 1, 0, 32'h0); a0 = obs_addr;
    n_cmp++;
    if (a0 !== exp_fetch) begin
      n_fail++; $display("FAIL stall_addr got=%h want=%h", a0, exp_fetch);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 0, 32'h0);
      n_cmp++;
      if (obs_addr !== a0) begin
        n_fail++; $display("FAIL stall_hold got=%h want=%h", obs_addr, a0);
      end
    end
    lat_lo = 0; lat_hi = 4; pops = 0;
    for (int i = 0; i < 400; i++) begin
      cycle(0, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, $urandom);
      if (obs_pop) pops++;
    end
    drain();
    n_cmp++;
    if (exp_dec !== exp_fetch || pops == 0) begin
      n_fail++; $display("FAIL random_loss got=%h want=%h pops=%0d", exp_dec, exp_fetch, pops);
    end
  endtask

  task automatic test_redirect();
    int k;
    drain();
    lat_lo = 3; lat_hi = 3;
    cycle(0, 1, 1, 0, 32'h0);
    cycle(0, 1, 1, 0, 32'h0);
    cycle(0, 1, 1, 1, 32'h0000_0103);
    lat_lo = 0; lat_hi = 0;
    cycle(0, 1, 1, 0, 32'h0);
    n_cmp++;
    if (obs_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL redir_addr got=%h want=00000100", obs_addr);
    end
    k = 0;
    while (!obs_pop && k < 20) begin cycle(0, 1, 1, 0, 32'h0); k++; end
    n_cmp++;
    if (!obs_pop || obs_pop_pc !== 32'h0000_0100) begin
      n_fail++; $display("FAIL redir_first_pc got=%h want=00000100", obs_pop_pc);
    end
  endtask

  task automatic test_wrap();
    int k;
    drain();
    lat_lo = 0; lat_hi = 0;
    cycle(0, 0, 1, 1, 32'hFFFF_FFFE);
    cycle(0, 1, 1, 0, 32'h0);
    n_cmp++;
    if (!obs_req || obs_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top got=%h want=fffffffc", obs_addr);
    end
    cycle(0, 1, 1, 0, 32'h0);
    n_cmp++;
    if (obs_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero got=%h want=00000000", obs_addr);
    end
    drain();
    lat_lo = 2; lat_hi = 2;
    cycle(0, 1, 1, 0, 32'h0);
    k = 0;
    while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && k < 10) begin
      cycle(0, 0, 1, 0, 32'h0); k++;
    end
    cycle(0, 0, 1, 1, 32'h0000_0200);
    @(posedge clk); #1;
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_rvalid_drop got=%b want=0", id_valid);
    end
    lat_lo = 0; lat_hi = 0;
    k = 0; obs_pop = 0;
    while (!obs_pop && k < 20) begin cycle(0, 1, 1, 0, 32'h0); k++; end
    n_cmp++;
    if (!obs_pop || obs_pop_pc !== 32'h0000_0200) begin
      n_fail++; $display("FAIL redir_rvalid_pc got=%h want=00000200", obs_pop_pc);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 32'h0);
    n_cmp++;
    if (id_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_full got=%b want=1", id_valid);
    end
    cycle(1, 1, 1, 1, 32'h0000_0080);
    @(posedge clk); #1;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got=%b%b want=00", id_valid, imem_req);
    end
    cycle(1, 0, 0, 0, 32'h0);
    cycle(0, 1, 1, 0, 32'h0);
    n_cmp++;
    if (!obs_req || obs_addr !== RST_PC) begin
      n_fail++; $display("FAIL mid_restart got=%b/%h want=1/%h", obs_req, obs_addr, RST_PC);
    end
    k = 0;
    while (!obs_pop && k < 20) begin cycle(0, 1, 1, 0, 32'h0); k++; end
    n_cmp++;
    if (!obs_pop || obs_pop_pc !== RST_PC) begin
      n_fail++; $display("FAIL mid_first_pc got=%h want=%h", obs_pop_pc, RST_PC);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; lat_lo = 0; lat_hi = 0;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    exp_fetch = RST_PC; exp_dec = RST_PC;
    obs_req = 0; obs_resp = 0; obs_pop = 0; obs_addr = 32'h0; obs_pop_pc = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
